// File: rtl/decoder_scan_nbit.sv
// ---------------------------------------------------------------------------
// decoder_scan_nbit
//   N-to-2^N one-hot decoder with registered outputs and a built-in scan
//   sequencer. Direct mode decodes x. Continuous scan walks idx 0..LAST
//   every DIV enabled cycles. Single sweep does one pass started by a start
//   pulse and ends with a done pulse. Hold freezes the sequencer.
//
// Ports
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   En    : enable; 0 blanks y and pauses the sequencer
//   mode  : 00 direct, 01 continuous scan, 10 single sweep, 11 hold
//   x     : external select (direct mode)
//   start : sweep launch pulse (mode 10 only)
//   y     : registered one-hot decode (one-cold when ACTIVE_LOW != 0)
//   idx   : sequencer index
//   step  : one-cycle pulse on the edge idx advances
//   busy  : sweep in progress
//   done  : one-cycle pulse when a sweep completes
// ---------------------------------------------------------------------------
module decoder_scan_nbit #(
  parameter int N          = 2,
  parameter int LAST       = (1 << N) - 1,
  parameter int DIV        = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                En,
  input  logic [1:0]          mode,
  input  logic [N-1:0]        x,
  input  logic                start,
  output logic [(1<<N)-1:0]   y,
  output logic [N-1:0]        idx,
  output logic                step,
  output logic                busy,
  output logic                done
);

  localparam int M  = 1 << N;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
  localparam logic [N-1:0]  IDX_LAST = N'(LAST);
  localparam logic [M-1:0]  Y_RST    = (ACTIVE_LOW != 0) ? {M{1'b1}} : {M{1'b0}};

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_SWEEP  = 2'b10;

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      mode_q;
  logic [PW-1:0]   pre_q, pre_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [M-1:0]    y_q, y_d;
  logic            step_q, step_d;
  logic            done_q, done_d;

  logic            mode_chg;
  logic            running;
  logic            launch;
  logic            abort;
  logic [N-1:0]    sel;
  logic            active;

  // One-hot decode of sel, blanked when inactive, polarity applied last.
  function automatic logic [M-1:0] decode(input logic [N-1:0] s, input logic act);
    logic [M-1:0] oh;
    oh = '0;
    if (act) oh[s] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  assign mode_chg = (mode != mode_q);
  assign running  = (mode == MODE_SCAN) || ((mode == MODE_SWEEP) && (state_q == S_SWEEP));
  assign launch   = (state_q == S_IDLE) && (mode == MODE_SWEEP) && start;
  // Leaving mode 10 mid-sweep ends the sweep silently (no done pulse).
  assign abort    = (state_q == S_SWEEP) && (mode != MODE_SWEEP);

  always_comb begin
    sel    = idx_q;
    active = 1'b1;
    case (mode)
      MODE_DIRECT: sel    = x;
      MODE_SWEEP:  active = (state_q == S_SWEEP);
      default:     active = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    idx_d   = idx_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    y_d     = decode(sel, En && active);
    if (launch) begin
      // Launch wins over the mode-change clear; both leave pre at 0.
      state_d = S_SWEEP;
      idx_d   = '0;
      pre_d   = '0;
    end else begin
      if (abort) state_d = S_IDLE;
      // A mode change restarts the step interval and never advances idx.
      if (mode_chg) begin
        pre_d = '0;
      end else if (running && En) begin
        if (pre_q == PRE_MAX) begin
          pre_d = '0;
          if ((state_q == S_SWEEP) && (idx_q == IDX_LAST)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + N'(1);
            step_d = 1'b1;
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
    end
  end

  // Register stage: all state and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_DIRECT;
      pre_q   <= '0;
      idx_q   <= '0;
      y_q     <= Y_RST;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign step = step_q;
  assign busy = (state_q == S_SWEEP);
  assign done = done_q;

endmodule

// File: tb/tb_decoder_scan_nbit.sv
// ---------------------------------------------------------------------------
// tb_decoder_scan_nbit
//   Three decoder instances share one stimulus stream:
//     0: N=2 LAST=3 DIV=4 active-high
//     1: N=3 LAST=5 DIV=2 active-high
//     2: N=2 LAST=3 DIV=3 active-low
//   A cycle-level reference model runs alongside; hand sequences add
//   constant expectations for the timing corners.
// ---------------------------------------------------------------------------
module tb_decoder_scan_nbit;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic       En = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] x = 3'd0;

  logic [3:0] yA, yC;
  logic [7:0] yB;
  logic [1:0] idxA, idxC;
  logic [2:0] idxB;
  logic       stepA, stepB, stepC;
  logic       busyA, busyB, busyC;
  logic       doneA, doneB, doneC;

  always #5 if (clk_en) clk = ~clk;

  decoder_scan_nbit #(.N(2), .LAST(3), .DIV(4), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst(rst), .En(En), .mode(mode), .x(x[1:0]), .start(start),
    .y(yA), .idx(idxA), .step(stepA), .busy(busyA), .done(doneA));

  decoder_scan_nbit #(.N(3), .LAST(5), .DIV(2), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst(rst), .En(En), .mode(mode), .x(x), .start(start),
    .y(yB), .idx(idxB), .step(stepB), .busy(busyB), .done(doneB));

  decoder_scan_nbit #(.N(2), .LAST(3), .DIV(3), .ACTIVE_LOW(1)) dut_c (
    .clk(clk), .rst(rst), .En(En), .mode(mode), .x(x[1:0]), .start(start),
    .y(yC), .idx(idxC), .step(stepC), .busy(busyC), .done(doneC));

  int checks = 0;
  int errors = 0;

  // Instance configurations for the reference model
  int CN[3]    = '{2, 3, 2};
  int CLAST[3] = '{3, 5, 3};
  int CDIV[3]  = '{4, 2, 3};
  int CAL[3]   = '{0, 0, 1};

  // Reference model state
  int m_mq[3];
  int m_cnt[3];
  int m_idx[3];
  int m_y[3];
  bit m_busy[3];
  bit m_step[3];
  bit m_done[3];

  function automatic int ymask(int i);
    return (1 << (1 << CN[i])) - 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_out(int i, int which);
    logic [31:0] r;
    r = '0;
    case (which)
      0: r = (i == 0) ? 32'(yA)    : (i == 1) ? 32'(yB)    : 32'(yC);
      1: r = (i == 0) ? 32'(idxA)  : (i == 1) ? 32'(idxB)  : 32'(idxC);
      2: r = (i == 0) ? 32'(stepA) : (i == 1) ? 32'(stepB) : 32'(stepC);
      3: r = (i == 0) ? 32'(busyA) : (i == 1) ? 32'(busyB) : 32'(busyC);
      default: r = (i == 0) ? 32'(doneA) : (i == 1) ? 32'(doneB) : 32'(doneC);
    endcase
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_mq[i] = 0; m_cnt[i] = 0; m_idx[i] = 0;
      m_busy[i] = 0; m_step[i] = 0; m_done[i] = 0;
      m_y[i] = (CAL[i] != 0) ? ymask(i) : 0;
    end
  endtask

  // One clock edge of behaviour, using the inputs present before the edge.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int sel;
      int ny;
      bit act;
      sel = m_idx[i];
      act = 1'b1;
      if (mode == 2'd0) sel = int'(x) % (1 << CN[i]);
      if (mode == 2'd2) act = m_busy[i];
      ny = (En && act) ? (1 << sel) : 0;
      if (CAL[i] != 0) ny = ~ny & ymask(i);
      m_step[i] = 0;
      m_done[i] = 0;
      if (!m_busy[i] && mode == 2'd2 && start) begin
        m_busy[i] = 1; m_idx[i] = 0; m_cnt[i] = 0;
      end else begin
        if (m_busy[i] && mode != 2'd2) m_busy[i] = 0;
        if (int'(mode) != m_mq[i]) begin
          m_cnt[i] = 0;
        end else if (En && (mode == 2'd1 || (mode == 2'd2 && m_busy[i]))) begin
          m_cnt[i]++;
          if (m_cnt[i] == CDIV[i]) begin
            m_cnt[i] = 0;
            if (mode == 2'd2 && m_idx[i] == CLAST[i]) begin
              m_busy[i] = 0; m_done[i] = 1; m_idx[i] = 0;
            end else begin
              m_idx[i] = (m_idx[i] + 1) % (CLAST[i] + 1);
              m_step[i] = 1;
            end
          end
        end
      end
      m_mq[i] = int'(mode);
      m_y[i]  = ny;
    end
  endtask

  task automatic compare_model();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_y%0d", i),    dut_out(i, 0), m_y[i]);
      chk($sformatf("model_idx%0d", i),  dut_out(i, 1), m_idx[i]);
      chk($sformatf("model_step%0d", i), dut_out(i, 2), int'(m_step[i]));
      chk($sformatf("model_busy%0d", i), dut_out(i, 3), int'(m_busy[i]));
      chk($sformatf("model_done%0d", i), dut_out(i, 4), int'(m_done[i]));
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    compare_model();
  endtask

  task automatic chk_reset_consts(input string tag);
    chk({tag, "_yA"}, 32'(yA), 0);
    chk({tag, "_yB"}, 32'(yB), 0);
    chk({tag, "_yC"}, 32'(yC), 15);
    chk({tag, "_idxB"}, 32'(idxB), 0);
    chk({tag, "_busyB"}, 32'(busyB), 0);
    chk({tag, "_stepB"}, 32'(stepB), 0);
    chk({tag, "_doneB"}, 32'(doneB), 0);
    chk({tag, "_busyA"}, 32'(busyA), 0);
    chk({tag, "_idxC"}, 32'(idxC), 0);
  endtask

  typedef struct {
    logic       en;
    logic [2:0] xv;
    logic [3:0] ea;
    logic [7:0] eb;
    logic [3:0] ec;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    bit found;

    tbl[0] = '{1'b1, 3'd0, 4'b0001, 8'b00000001, 4'b1110};
    tbl[1] = '{1'b1, 3'd1, 4'b0010, 8'b00000010, 4'b1101};
    tbl[2] = '{1'b1, 3'd2, 4'b0100, 8'b00000100, 4'b1011};
    tbl[3] = '{1'b1, 3'd3, 4'b1000, 8'b00001000, 4'b0111};
    tbl[4] = '{1'b1, 3'd7, 4'b1000, 8'b10000000, 4'b0111};
    tbl[5] = '{1'b0, 3'd5, 4'b0000, 8'b00000000, 4'b1111};
    tbl[6] = '{1'b1, 3'd6, 4'b0100, 8'b01000000, 4'b1011};

    // Reset with the clock stopped
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk_reset_consts("rst_noclk");
    clk_en = 1'b1;
    #1 rst = 1'b0;
    En = 1'b1;
    mode = 2'b00;

    // Direct mode vectors
    for (int v = 0; v < 7; v++) begin
      En = tbl[v].en;
      x  = tbl[v].xv;
      tick_clk();
      chk($sformatf("direct_yA[%0d]", v), 32'(yA), int'(tbl[v].ea));
      chk($sformatf("direct_yB[%0d]", v), 32'(yB), int'(tbl[v].eb));
      chk($sformatf("direct_yC[%0d]", v), 32'(yC), int'(tbl[v].ec));
    end

    // Continuous scan on instance 0: step every 4 cycles, idx 1,2,3,0
    En = 1'b1; x = 3'd0; mode = 2'b01;
    tick_clk();
    for (int k = 1; k <= 16; k++) begin
      tick_clk();
      chk($sformatf("scanA_step[%0d]", k), 32'(stepA), (k % 4 == 0) ? 1 : 0);
      chk($sformatf("scanA_idx[%0d]", k), 32'(idxA), (k / 4) % 4);
    end
    // Pause for 5 cycles mid-interval; the interval stretches by 5
    gap = 0;
    tick_clk(); gap++;
    tick_clk(); gap++;
    En = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick_clk(); gap++;
      chk("pauseA_idx", 32'(idxA), 0);
      chk("pauseA_y", 32'(yA), 0);
      chk("pauseA_step", 32'(stepA), 0);
    end
    En = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick_clk(); gap++;
      if (stepA) found = 1'b1;
    end
    chk("pauseA_gap", 32'(gap), 9);

    // Single sweep on instance 1, with an ignored second start
    mode = 2'b10; start = 1'b1;
    tick_clk();
    start = 1'b0;
    chk("sweepB_busy_rise", 32'(busyB), 1);
    chk("sweepB_idx0", 32'(idxB), 0);
    for (int k = 1; k <= 14; k++) begin
      start = (k == 4);
      tick_clk();
      chk($sformatf("sweepB_y[%0d]", k), 32'(yB), (k <= 12) ? (1 << ((k - 1) / 2)) : 0);
      chk($sformatf("sweepB_busy[%0d]", k), 32'(busyB), (k < 12) ? 1 : 0);
      chk($sformatf("sweepB_done[%0d]", k), 32'(doneB), (k == 12) ? 1 : 0);
    end
    start = 1'b0;
    chk("sweepB_idx_end", 32'(idxB), 0);

    // Abort: leave mode 10 mid-sweep with the prescaler at 1
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick_clk();
    mode = 2'b01;
    tick_clk();
    chk("abortB_busy", 32'(busyB), 0);
    chk("abortB_done", 32'(doneB), 0);
    chk("abortB_idx", 32'(idxB), 2);
    tick_clk();
    chk("abortB_nostep", 32'(stepB), 0);
    chk("abortB_idx_hold", 32'(idxB), 2);
    tick_clk();
    chk("abortB_step", 32'(stepB), 1);
    chk("abortB_idx_next", 32'(idxB), 3);

    // Hold on the active-low instance once its index reaches 2
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick_clk();
      if (m_idx[2] == 2) found = 1'b1;
    end
    chk("holdC_reached", 32'(found), 1);
    mode = 2'b11;
    for (int k = 0; k < 20; k++) begin
      tick_clk();
      chk($sformatf("holdC_y[%0d]", k), 32'(yC), 4'b1011);
      chk($sformatf("holdC_idx[%0d]", k), 32'(idxC), 2);
    end
    En = 1'b0;
    tick_clk();
    chk("holdC_en0_y", 32'(yC), 4'b1111);

    // Asynchronous reset between edges in the middle of a sweep
    En = 1'b1; mode = 2'b10; start = 1'b1;
    tick_clk();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick_clk();
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk_reset_consts("rst_async");
    #2 rst = 1'b0;
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    chk("post_rst_busyB", 32'(busyB), 1);
    chk("post_rst_idxB", 32'(idxB), 0);
    tick_clk();
    chk("post_rst_yA", 32'(yA), 1);
    chk("post_rst_yB", 32'(yB), 1);
    chk("post_rst_yC", 32'(yC), 4'b1110);

    // Randomized traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      En = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      start = ($urandom_range(0, 5) == 0);
      x = 3'($urandom_range(0, 7));
      tick_clk();
      if ($urandom_range(0, 149) == 0) begin
        #3 rst = 1'b1;
        #1;
        model_reset();
        compare_model();
        #2 rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
